// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helpers
// so the emitter and receiver derive their bit periods identically.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    function automatic int uart_bit_cycles(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

    function automatic int uart_half_cycles(input int clk_freq_hz, input int baud_rate);
        return uart_bit_cycles(clk_freq_hz, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous signals into the
// clk domain; the reset value lets idle-high lines come out of reset idle.
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised line, byte delivery
// through a valid/ack handshake, framing-error pulse and sticky overrun flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int clk_freq_hz = 25000000,
    parameter int baud_rate   = 115200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ack,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int BIT_CYCLES  = uart_bit_cycles(clk_freq_hz, baud_rate);
    localparam int HALF_CYCLES = uart_half_cycles(clk_freq_hz, baud_rate);
    localparam int CNT_W       = $clog2(BIT_CYCLES);
    localparam int IDX_W       = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    if (BIT_CYCLES < 4) begin : g_bit_cycles_check
        $error("uart_receiver: clk_freq_hz/baud_rate must be at least 4");
    end

    uart_rx_state_t            state;
    logic                      rxs;
    logic [CNT_W-1:0]          count;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      expired;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rx),
        .q   (rxs)
    );

    assign expired = (count == '0);

    // Later assignments in the case deliberately override the ack clear, so a
    // byte landing in the same cycle as an ack replaces the acknowledged one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            if (!expired) begin
                count <= count - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        count <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (expired) begin
                        if (!rxs) begin
                            count   <= BIT_LOAD;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (expired) begin
                        shift   <= {rxs, shift[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        count   <= BIT_LOAD;
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (expired) begin
                        if (rxs) begin
                            if (!rx_valid || rx_ack) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end
                // A held-low line must not be mistaken for a train of start bits.
                WAIT_IDLE: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
